// File: rtl/aes_key_scheduler.sv
// AES-128/AES-256 key expansion: one 128-bit round key per clock into a
// readable round-key store, plus the word-level S-box it relies on.

module aes_sbox (
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) begin
                p = p ^ aa;
            end else begin
                p = p;
            end
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0), followed by the affine map.
    function automatic logic [7:0] sbox_byte(input logic [7:0] x);
        logic [7:0] acc;
        logic [7:0] pw;
        acc = 8'h01;
        pw  = x;
        for (int k = 0; k < 8; k++) begin
            if (k >= 1) begin
                acc = gf_mul(acc, pw);
            end else begin
                acc = acc;
            end
            pw = gf_mul(pw, pw);
        end
        return acc ^ {acc[6:0], acc[7]} ^ {acc[5:0], acc[7:6]}
                   ^ {acc[4:0], acc[7:5]} ^ {acc[3:0], acc[7:4]} ^ 8'h63;
    endfunction

    // Byte-wise substitution of the whole word.
    always_comb begin
        word_o = 32'h0;
        for (int k = 0; k < 4; k++) begin
            word_o[8*k +: 8] = sbox_byte(word_i[8*k +: 8]);
        end
    end

endmodule

module aes_key_scheduler #(
    parameter int NK = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NK*32-1:0] key_in,
    input  logic            key_valid,
    output logic            key_ready,
    input  logic [3:0]      rk_idx,
    output logic [127:0]    rk_out,
    output logic            busy,
    output logic            done
);

    localparam int NR        = NK + 6;
    localparam int WIN_W     = NK * 32;
    localparam int FIRST_IDX = (NK == 8) ? 2 : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         idx_q, idx_d;
    logic [7:0]         rc_q, rc_d;
    logic [15:0]        valid_q, valid_d;
    logic [WIN_W-1:0]   win_q, win_d;
    logic [127:0]       rk_q [NR+1];
    logic [127:0]       rk_d [NR+1];

    logic               use_rot_s;
    logic [31:0]        last_w_s, sbox_in_s, sub_w_s, f_w_s;
    logic [31:0]        n0_s, n1_s, n2_s, n3_s;
    logic [127:0]       new_rk_s;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // With NK=8 the round keys alternate between the Rcon step (even idx) and plain SubWord.
    assign last_w_s  = win_q[31:0];
    assign use_rot_s = (NK == 4) || !idx_q[0];
    assign sbox_in_s = use_rot_s ? {last_w_s[23:0], last_w_s[31:24]} : last_w_s;

    aes_sbox u_sbox (
        .word_i (sbox_in_s),
        .word_o (sub_w_s)
    );

    assign f_w_s    = use_rot_s ? (sub_w_s ^ {rc_q, 24'h000000}) : sub_w_s;
    assign n0_s     = win_q[WIN_W-1  -: 32] ^ f_w_s;
    assign n1_s     = win_q[WIN_W-33 -: 32] ^ n0_s;
    assign n2_s     = win_q[WIN_W-65 -: 32] ^ n1_s;
    assign n3_s     = win_q[WIN_W-97 -: 32] ^ n2_s;
    assign new_rk_s = {n0_s, n1_s, n2_s, n3_s};

    // Next-state, window, Rcon and key-store update.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rc_d    = rc_q;
        valid_d = valid_q;
        win_d   = win_q;
        rk_d    = rk_q;
        case (state_q)
            IDLE, DONE: begin
                if (key_valid) begin
                    state_d = EXPAND;
                    idx_d   = 4'(FIRST_IDX);
                    rc_d    = 8'h01;
                    win_d   = key_in;
                    rk_d[0] = key_in[WIN_W-1 -: 128];
                    valid_d = 16'h0001;
                    if (NK == 8) begin
                        rk_d[1] = key_in[127:0];
                        valid_d = 16'h0003;
                    end else begin
                        valid_d = 16'h0001;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            EXPAND: begin
                rk_d[idx_q]    = new_rk_s;
                valid_d[idx_q] = 1'b1;
                idx_d          = idx_q + 4'd1;
                win_d          = (win_q << 128) | WIN_W'(new_rk_s);
                if (use_rot_s) begin
                    rc_d = xtime(rc_q);
                end else begin
                    rc_d = rc_q;
                end
                if (idx_q == 4'(NR)) begin
                    state_d = DONE;
                end else begin
                    state_d = EXPAND;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
            rc_q    <= 8'h01;
            valid_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rc_q    <= rc_d;
            valid_q <= valid_d;
        end
    end

    // Key data is not cleared on reset; the valid flags hide it, and reset blocks writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_q <= win_q;
            for (int k = 0; k <= NR; k++) begin
                rk_q[k] <= rk_q[k];
            end
        end else begin
            win_q <= win_d;
            for (int k = 0; k <= NR; k++) begin
                rk_q[k] <= rk_d[k];
            end
        end
    end

    assign key_ready = (state_q == IDLE) || (state_q == DONE);
    assign busy      = (state_q == EXPAND);
    assign done      = (state_q == DONE);

    // Combinational read; out-of-range or not-yet-written indices read as zero.
    always_comb begin
        if ((rk_idx <= 4'(NR)) && valid_q[rk_idx]) begin
            rk_out = rk_q[rk_idx];
        end else begin
            rk_out = 128'h0;
        end
    end

endmodule

// File: tb/tb_aes_key_scheduler.sv
// Directed, table-driven bench for aes_key_scheduler with NK=4 and NK=8 instances.

module tb_aes_key_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [127:0] key_a;
    logic         kv_a, kr_a, busy_a, done_a;
    logic [3:0]   idx_a;
    logic [127:0] rk_a;
    logic [255:0] key_b;
    logic         kv_b, kr_b, busy_b, done_b;
    logic [3:0]   idx_b;
    logic [127:0] rk_b;

    aes_key_scheduler #(.NK(4)) dut_a (
        .clk(clk), .rst(rst), .key_in(key_a), .key_valid(kv_a), .key_ready(kr_a),
        .rk_idx(idx_a), .rk_out(rk_a), .busy(busy_a), .done(done_a)
    );

    aes_key_scheduler #(.NK(8)) dut_b (
        .clk(clk), .rst(rst), .key_in(key_b), .key_valid(kv_b), .key_ready(kr_b),
        .rk_idx(idx_b), .rk_out(rk_b), .busy(busy_b), .done(done_b)
    );

    localparam logic [255:0] K1 = 256'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [255:0] K2 = 256'h000102030405060708090a0b0c0d0e0f;
    localparam logic [255:0] K3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] K1_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] K1_RK2  = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] K1_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    typedef struct {
        bit           sel8;
        logic [255:0] key;
        logic [3:0]   idx;
        logic [127:0] expv;
    } vec_t;

    vec_t vecs [17];
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, expv);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic read_rk(input bit sel8, input logic [3:0] i, output logic [127:0] v);
        if (sel8) idx_b = i;
        else      idx_a = i;
        #1;
        v = sel8 ? rk_b : rk_a;
    endtask

    task automatic chk_all_zero(input bit sel8, input string name);
        logic [127:0] acc;
        logic [127:0] v;
        acc = 128'h0;
        for (int i = 0; i < 16; i++) begin
            read_rk(sel8, 4'(i), v);
            acc = acc | v;
        end
        chk(name, acc, 128'h0);
    endtask

    // Wait (bounded) for done; returns cycles after the point of call, -1 on timeout.
    task automatic wait_done(input bit sel8, output int lat);
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if ((sel8 ? done_b : done_a) === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic handshake(input bit sel8, input logic [255:0] key);
        @(posedge clk); #1;
        if (sel8) begin key_b = key; kv_b = 1'b1; end
        else      begin key_a = key[127:0]; kv_a = 1'b1; end
        @(posedge clk); #1;
        kv_a = 1'b0; kv_b = 1'b0;
        key_a = 128'h0; key_b = 256'h0;
    endtask

    task automatic load(input bit sel8, input logic [255:0] key, output int lat);
        handshake(sel8, key);
        chk_bit("busy_after_e0", sel8 ? busy_b : busy_a, 1'b1);
        chk_bit("ready_after_e0", sel8 ? kr_b : kr_a, 1'b0);
        wait_done(sel8, lat);
    endtask

    initial begin
        logic [255:0] cur_key [2];
        bit           loaded  [2];
        logic [127:0] v;
        int           lat;

        vecs[0]  = '{1'b0, K1, 4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
        vecs[1]  = '{1'b0, K1, 4'd1,  K1_RK1};
        vecs[2]  = '{1'b0, K1, 4'd2,  K1_RK2};
        vecs[3]  = '{1'b0, K1, 4'd10, K1_RK10};
        vecs[4]  = '{1'b0, K1, 4'd11, 128'h0};
        vecs[5]  = '{1'b0, K1, 4'd12, 128'h0};
        vecs[6]  = '{1'b0, K1, 4'd13, 128'h0};
        vecs[7]  = '{1'b0, K1, 4'd14, 128'h0};
        vecs[8]  = '{1'b0, K1, 4'd15, 128'h0};
        vecs[9]  = '{1'b0, K2, 4'd0,  128'h000102030405060708090a0b0c0d0e0f};
        vecs[10] = '{1'b0, K2, 4'd1,  128'hd6aa74fdd2af72fadaa678f1d6ab76fe};
        vecs[11] = '{1'b0, K2, 4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5};
        vecs[12] = '{1'b1, K3, 4'd0,  128'h000102030405060708090a0b0c0d0e0f};
        vecs[13] = '{1'b1, K3, 4'd1,  128'h101112131415161718191a1b1c1d1e1f};
        vecs[14] = '{1'b1, K3, 4'd2,  128'ha573c29fa176c498a97fce93a572c09c};
        vecs[15] = '{1'b1, K3, 4'd14, 128'h24fc79ccbf0979e9371ac23c6d68de36};
        vecs[16] = '{1'b1, K3, 4'd15, 128'h0};

        rst = 1'b1;
        kv_a = 1'b0; kv_b = 1'b0;
        key_a = 128'h0; key_b = 256'h0;
        idx_a = 4'd0; idx_b = 4'd0;
        loaded[0] = 1'b0; loaded[1] = 1'b0;
        cur_key[0] = 256'h0; cur_key[1] = 256'h0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        chk_bit("reset_ready_a", kr_a, 1'b1);
        chk_bit("reset_busy_a", busy_a, 1'b0);
        chk_bit("reset_done_a", done_a, 1'b0);
        chk_bit("reset_ready_b", kr_b, 1'b1);
        chk_bit("reset_done_b", done_b, 1'b0);
        chk_all_zero(1'b0, "reset_rk_zero_a");
        chk_all_zero(1'b1, "reset_rk_zero_b");

        for (int n = 0; n < 17; n++) begin
            int s;
            s = vecs[n].sel8 ? 1 : 0;
            if (!loaded[s] || cur_key[s] != vecs[n].key) begin
                load(vecs[n].sel8, vecs[n].key, lat);
                chk_int($sformatf("latency_vec%0d", n), lat, vecs[n].sel8 ? 13 : 10);
                loaded[s]  = 1'b1;
                cur_key[s] = vecs[n].key;
            end
            read_rk(vecs[n].sel8, vecs[n].idx, v);
            chk($sformatf("vec%0d_rk%0d", n, vecs[n].idx), v, vecs[n].expv);
        end

        // A second key offered during expansion must be ignored.
        handshake(1'b0, K1);
        key_a = K2[127:0];
        kv_a  = 1'b1;
        chk_bit("expand_ready_low", kr_a, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk_bit("expand_ready_still_low", kr_a, 1'b0);
        kv_a = 1'b0;
        wait_done(1'b0, lat);
        chk_int("expand_ignore_done_seen", (lat > 0) ? 1 : 0, 1);
        read_rk(1'b0, 4'd10, v);
        chk("expand_ignore_rk10", v, K1_RK10);

        // Same key again in DONE: done drops, stale keys hidden, then identical result.
        handshake(1'b0, K1);
        chk_bit("restart_done_low", done_a, 1'b0);
        chk_bit("restart_busy", busy_a, 1'b1);
        read_rk(1'b0, 4'd10, v);
        chk("restart_stale_rk10", v, 128'h0);
        read_rk(1'b0, 4'd2, v);
        chk("restart_stale_rk2", v, 128'h0);
        read_rk(1'b0, 4'd0, v);
        chk("restart_rk0", v, K1[127:0]);
        wait_done(1'b0, lat);
        chk_int("restart_latency", lat, 10);
        read_rk(1'b0, 4'd10, v);
        chk("restart_rk10", v, K1_RK10);
        read_rk(1'b0, 4'd1, v);
        chk("restart_rk1", v, K1_RK1);

        // Reset pulsed four edges after E0 aborts the expansion.
        handshake(1'b0, K2);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk_bit("abort_busy", busy_a, 1'b0);
        chk_bit("abort_done", done_a, 1'b0);
        chk_bit("abort_ready", kr_a, 1'b1);
        chk_all_zero(1'b0, "abort_rk_zero");
        repeat (12) @(posedge clk);
        #1;
        chk_bit("abort_stays_idle", busy_a, 1'b0);
        chk_all_zero(1'b0, "abort_rk_zero_later");

        // Reset wins over a simultaneous handshake.
        @(posedge clk);
        #1 rst = 1'b1; kv_a = 1'b1; key_a = K1[127:0];
        @(posedge clk);
        #1 rst = 1'b0; kv_a = 1'b0;
        chk_bit("rst_prio_busy", busy_a, 1'b0);
        read_rk(1'b0, 4'd0, v);
        chk("rst_prio_rk0", v, 128'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
